// File: rtl/reg_file_sb.sv
// Parametrised 2-read/1-write register file with a pending-write scoreboard,
// optional write-to-read bypass, optional hardwired zero entry and a post-reset clear sequence.
module reg_file_sb #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 16,
  parameter bit          BYPASS     = 1'b1,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  rd_pend_a,
  output logic                  rd_pend_b,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  sb_set,
  input  logic [ADDR_WIDTH-1:0] sb_addr,
  output logic                  busy
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic [DEPTH-1:0]      r_pend;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_run;
  logic                  w_wr_ok;
  logic                  w_sb_ok;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;

  assign w_run   = (r_state == ST_RUN);
  assign busy    = (r_state == ST_INIT);
  // Entry 0 swallows writes and scoreboard marks when it is hardwired to zero.
  assign w_wr_ok = w_run && wr_en  && !(ZERO_REG && (wr_addr == '0));
  assign w_sb_ok = w_run && sb_set && !(ZERO_REG && (sb_addr == '0));

  // Single storage write port shared by the clear sequence and writeback.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = r_clr_cnt;
    w_mem_wdata = '0;
    if (!w_run) begin
      w_mem_we = 1'b1;
    end else if (w_wr_ok) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = wr_addr;
      w_mem_wdata = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // Control state: clear sequence, then scoreboard maintenance (set beats clear).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_INIT;
      r_clr_cnt <= '0;
      r_pend    <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_clr_cnt <= r_clr_cnt + ADDR_WIDTH'(1);
          if (r_clr_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          if (w_wr_ok) begin
            r_pend[wr_addr] <= 1'b0;
          end
          if (w_sb_ok) begin
            r_pend[sb_addr] <= 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    rd_data_a = '0;
    if (w_run && !(ZERO_REG && (rd_addr_a == '0))) begin
      if (BYPASS && wr_en && (wr_addr == rd_addr_a)) begin
        rd_data_a = wr_data;
      end else begin
        rd_data_a = r_mem[rd_addr_a];
      end
    end
  end

  always_comb begin
    rd_data_b = '0;
    if (w_run && !(ZERO_REG && (rd_addr_b == '0))) begin
      if (BYPASS && wr_en && (wr_addr == rd_addr_b)) begin
        rd_data_b = wr_data;
      end else begin
        rd_data_b = r_mem[rd_addr_b];
      end
    end
  end

  // Pending flags come straight from the registered scoreboard.
  assign rd_pend_a = w_run && r_pend[rd_addr_a];
  assign rd_pend_b = w_run && r_pend[rd_addr_b];

endmodule
